// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and baud helpers.
package uart_pkg;

  typedef logic [2:0] uart_rx_state_t;

  localparam uart_rx_state_t RX_IDLE      = 3'd0;
  localparam uart_rx_state_t RX_START     = 3'd1;
  localparam uart_rx_state_t RX_DATA      = 3'd2;
  localparam uart_rx_state_t RX_STOP      = 3'd3;
  localparam uart_rx_state_t RX_WAIT_IDLE = 3'd4;

  typedef logic [1:0] uart_tx_state_t;

  localparam uart_tx_state_t TX_IDLE  = 2'd0;
  localparam uart_tx_state_t TX_START = 2'd1;
  localparam uart_tx_state_t TX_DATA  = 2'd2;
  localparam uart_tx_state_t TX_STOP  = 2'd3;

  function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
    return clk_freq_hz / baud;
  endfunction

  // Bits needed to hold a count of 0 .. n-1, never less than one bit.
  function automatic int timer_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs with a configurable reset value.
module sync_2ff #(
  parameter int   WIDTH     = 1,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1_r;

  // Metastability filter: the first stage may go metastable, the second resolves it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage1_r <= {WIDTH{RESET_VAL}};
      q        <= {WIDTH{RESET_VAL}};
    end else begin
      stage1_r <= d;
      q        <= stage1_r;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, framing-error detection, one-cycle result strobes.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] RX,
  output logic       RX_ready,
  output logic       frame_error,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TIMER_W      = timer_width(CLKS_PER_BIT);

  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(HALF_BIT - 1);

  logic               line_s;
  uart_rx_state_t     state_r;
  logic [TIMER_W-1:0] timer_r;
  logic [2:0]         bit_idx_r;
  logic [7:0]         shift_r;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (line_s)
  );

  assign busy = (state_r != RX_IDLE);

  // Receive FSM; the strobes default low so each pulse lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= RX_IDLE;
      timer_r     <= '0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      RX          <= 8'h00;
      RX_ready    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      RX_ready    <= 1'b0;
      frame_error <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          timer_r <= '0;
          if (line_s == 1'b0) begin
            state_r <= RX_START;
          end
        end
        RX_START: begin
          if (timer_r == HALF_LAST) begin
            timer_r   <= '0;
            bit_idx_r <= 3'd0;
            // A start bit that is no longer low at its centre was a glitch.
            state_r   <= (line_s == 1'b0) ? RX_DATA : RX_IDLE;
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        RX_DATA: begin
          if (timer_r == BIT_LAST) begin
            timer_r   <= '0;
            shift_r   <= {line_s, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
              state_r <= RX_STOP;
            end
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        RX_STOP: begin
          if (timer_r == BIT_LAST) begin
            timer_r <= '0;
            if (line_s == 1'b1) begin
              RX       <= shift_r;
              RX_ready <= 1'b1;
              state_r  <= RX_IDLE;
            end else begin
              frame_error <= 1'b1;
              state_r     <= RX_WAIT_IDLE;
            end
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        RX_WAIT_IDLE: begin
          timer_r <= '0;
          if (line_s == 1'b1) begin
            state_r <= RX_IDLE;
          end
        end
        default: begin
          state_r <= RX_IDLE;
          timer_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning serial bit rate in bits per second.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port serial_in, input, 1 bit: asynchronous RS232 line, 8N1, idle high.
REQ-006 SHALL have port RX, output, 8 bits: last correctly framed byte.
REQ-007 SHALL have port RX_ready, output, 1 bit: one-cycle pulse, RX valid this cycle.
REQ-008 SHALL have port frame_error, output, 1 bit: one-cycle pulse when a stop bit samples 0.
REQ-009 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-010 SHALL compute CLKS_PER_BIT = CLK_FREQ_HZ / BAUD (truncating integer division) and HALF_BIT = CLKS_PER_BIT / 2; 50 MHz / 115200 gives 434 / 217.
REQ-011 SHALL pass serial_in through a two-flop synchronizer reset to 1; the FSM SHALL only see the synchronized value (line_s).
REQ-012 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-013 IDLE: on line_s == 0, clear bit timer and go to START.
REQ-014 START: at timer == HALF_BIT-1, resample; 0 -> DATA with timer cleared and bit index 0; 1 -> IDLE (glitch rejected, no outputs).
REQ-015 DATA: at timer == CLKS_PER_BIT-1, shift line_s into shift register, LSB first, clear timer, increment 3-bit index; after index 7 is sampled, go to STOP.
REQ-016 STOP: at timer == CLKS_PER_BIT-1, line_s == 1 -> RX <= shift register, RX_ready <= 1 for exactly one cycle, go IDLE.
REQ-017 STOP with line_s == 0 -> frame_error <= 1 for one cycle, RX unchanged, no RX_ready, go WAIT_IDLE.
REQ-018 WAIT_IDLE: remain until line_s == 1, then go IDLE; a held-low line (break) SHALL produce exactly one frame_error.
REQ-019 Return to IDLE at mid-stop-bit SHALL allow back-to-back frames with zero idle bits.
REQ-020 RX_ready SHALL be asserted registered, HALF_BIT + 9*CLKS_PER_BIT + 2 cycles (synchronizer) ± 1 after the serial_in falling edge of the start bit.
REQ-021 RX SHALL hold its value until the next good frame; no consumer acknowledge exists; a byte not taken on the RX_ready cycle is lost.
REQ-022 Bit timer SHALL be wide enough for CLKS_PER_BIT-1 and SHALL never wrap within a bit.
REQ-023 busy SHALL be combinational from state; RX, RX_ready, frame_error SHALL be registered.

Reset
REQ-024 On rst low: state IDLE, RX = 8'h00, RX_ready = 0, frame_error = 0, timer, index, shift register = 0, synchronizer flops = 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame without pulsing RX_ready or frame_error; after release a line still low SHALL be treated as a new start bit.

Structure
REQ-026 The state enum (uart_rx_state_t) SHALL live in shared package uart_pkg, alongside the transmitter's definitions.
REQ-027 The synchronizer SHALL be sub-module sync_2ff (parameterised reset value), reused by other async inputs.
REQ-028 Outputs RX and RX_ready SHALL connect directly to SerialCommandProcessor's RX and RX_ready.

Verification (CLK_FREQ_HZ=1000, BAUD=100 -> CLKS_PER_BIT=10)
REQ-029 Send 0xA5, 8N1 -> RX == 8'hA5, one RX_ready pulse, busy high for the frame, no frame_error.
REQ-030 Send 0x00 then 0xFF back-to-back, no idle bits -> two RX_ready pulses, RX 8'h00 then 8'hFF.
REQ-031 Low glitch of 3 clocks on idle line -> no RX_ready, no frame_error, busy returns low within 7 clocks.
REQ-032 Send 0x3C with stop bit 0, line held low 50 clocks -> single frame_error pulse, RX unchanged, busy until line high.
REQ-033 Assert rst during DATA bit 4 of 0x81 -> all outputs at reset values, no pulses; a subsequent clean 0x81 is received correctly.
